kuznechik_crypt: RTL and testbench

Iterative GOST R 34.12-2015 (Kuznyechik) block engine for 128-bit blocks. It encrypts or decrypts each block, selected per request. Round keys are loaded at run time through a write port, not baked in at elaboration. A parameter trades area for latency by unrolling the linear layer. It drops into the existing cipher slot and keeps the request/busy/valid/ack handshake the rest of the design already uses.

---
 rtl/kuznechik_pkg.sv | 67 ++++++
 rtl/kuznechik_r_step.sv | 24 ++
 rtl/kuznechik_crypt.sv | 156 +++++++++++++++
 tb/tb_kuznechik_crypt.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kuznechik_pkg.sv
// Kuznyechik shared constants: S-boxes, L coefficients, GF(2^8) multiply.
// Also holds FSM encodings and block geometry for the iterative engine.
package kuznechik_pkg;

  localparam int BLK_W = 128;
  localparam int N_RK  = 10;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_SUB  = 3'd2;
  localparam logic [2:0] S_LIN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef logic [0:255][7:0] sbox_t;

  localparam sbox_t PI = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D,
    128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F,
    128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC,
    128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1,
    128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903,
    128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641,
    128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789,
    128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52,
    128'h59A674D2E6F4B4C0D166AFC2394B63B6
  };

  function automatic sbox_t inv_sbox(input sbox_t t);
    sbox_t r;
    r = '0;
    for (int i = 0; i < 256; i++) r[t[i]] = 8'(i);
    return r;
  endfunction

  localparam sbox_t PI_INV = inv_sbox(PI);

  // Index 0 multiplies b15, index 15 multiplies b0.
  localparam logic [0:15][7:0] L_COEF = {
    8'd148, 8'd32,  8'd133, 8'd16,
    8'd194, 8'd192, 8'd1,   8'd251,
    8'd1,   8'd192, 8'd194, 8'd16,
    8'd133, 8'd32,  8'd148, 8'd1
  };

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
    end
    return p;
  endfunction

endpackage

// File: rtl/kuznechik_r_step.sv
// One combinational LFSR step of the Kuznyechik linear layer.
// dec_i selects the inverse step R^-1 instead of R.
module kuznechik_r_step
  import kuznechik_pkg::*;
(
  input  logic             dec_i,
  input  logic [BLK_W-1:0] data_i,
  output logic [BLK_W-1:0] data_o
);

  logic [BLK_W-1:0] v;
  logic [7:0]       l;

  // Inverse step feeds the rotated block {b14..b0,b15} into l.
  always_comb begin
    v = dec_i ? {data_i[119:0], data_i[127:120]} : data_i;
    l = '0;
    for (int j = 0; j < 16; j++)
      l = l ^ gf_mul(L_COEF[15-j], v[8*j +: 8]);
    data_o = dec_i ? {data_i[119:0], l}
                   : {l, data_i[127:8]};
  end

endmodule

// File: rtl/kuznechik_crypt.sv
// Iterative Kuznyechik encrypt/decrypt engine with loadable round keys.
// L_UNROLL R-steps per cycle in the linear phase trade area for latency.
module kuznechik_crypt
  import kuznechik_pkg::*;
#(
  parameter int L_UNROLL = 1
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             key_we_i,
  input  logic [3:0]       key_addr_i,
  input  logic [BLK_W-1:0] key_data_i,
  input  logic             request_i,
  input  logic             mode_i,
  input  logic [BLK_W-1:0] data_i,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [BLK_W-1:0] data_o
);

  localparam int NSTEP = 16 / L_UNROLL;
  localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSTEP - 1);

  if (L_UNROLL != 1 && L_UNROLL != 2 && L_UNROLL != 4 &&
      L_UNROLL != 8 && L_UNROLL != 16) begin : g_bad_unroll
    $error("L_UNROLL must be 1, 2, 4, 8 or 16");
  end

  logic [2:0]       state_q, state_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [BLK_W-1:0] dout_q, dout_d;
  logic [BLK_W-1:0] key_q [N_RK];

  logic [3:0]       kidx;
  logic [BLK_W-1:0] rk;
  logic [BLK_W-1:0] sub;
  logic [BLK_W-1:0] chain [L_UNROLL+1];

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign data_o  = dout_q;

  assign kidx = dec_q ? (4'd9 - rnd_q) : rnd_q;
  assign rk   = key_q[kidx];

  assign chain[0] = data_q;
  for (genvar g = 0; g < L_UNROLL; g++) begin : g_r
    kuznechik_r_step u_r (
      .dec_i  (dec_q),
      .data_i (chain[g]),
      .data_o (chain[g+1])
    );
  end

  // Byte-wise substitution, forward or inverse table.
  always_comb begin
    sub = '0;
    for (int j = 0; j < 16; j++)
      sub[8*j +: 8] = dec_q ? PI_INV[data_q[8*j +: 8]]
                            : PI[data_q[8*j +: 8]];
  end

  // Round-key file: writable only while no block is in flight.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < N_RK; i++) key_q[i] <= '0;
    end else if (key_we_i && !busy_q && key_addr_i < 4'd10) begin
      key_q[key_addr_i] <= key_data_i;
    end
  end

  // Round sequencer: KEY/SUB/LIN order flips between enc and dec.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rnd_d   = rnd_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (request_i) begin
          data_d  = data_i;
          dec_d   = mode_i;
          rnd_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_KEY;
        end else if (state_q == S_DONE && ack_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_KEY: begin
        data_d = data_q ^ rk;
        if (rnd_q == 4'd9) begin
          dout_d  = data_q ^ rk;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          rnd_d   = rnd_q + 4'd1;
          state_d = dec_q ? S_LIN : S_SUB;
        end
      end
      S_SUB: begin
        data_d  = sub;
        state_d = dec_q ? S_KEY : S_LIN;
      end
      S_LIN: begin
        data_d = chain[L_UNROLL];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = dec_q ? S_SUB : S_KEY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and control registers; reset aborts any block at once.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      rnd_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rnd_q   <= rnd_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_kuznechik_crypt.sv
// Scoreboard bench for kuznechik_crypt over all legal L_UNROLL values.
// Instance 0 (L_UNROLL=1) runs every scenario; the others run the A.1 vectors.
module tb_kuznechik_crypt;

  localparam int NI = 5;
  localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
  localparam logic [127:0] KA [10] = '{
    128'h8899aabbccddeeff0011223344556677,
    128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44,
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac,
    128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1,
    128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517,
    128'h72e9dd7416bcf45b755dbaa88e4a4043
  };
  localparam logic [0:255][7:0] PI_REF = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D,
    128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F,
    128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC,
    128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1,
    128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903,
    128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641,
    128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789,
    128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52,
    128'h59A674D2E6F4B4C0D166AFC2394B63B6
  };
  localparam logic [7:0] COEF [16] = '{
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  typedef struct {
    logic [127:0] d;
    int           lat;
    int           t0;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_we = 1'b0;
  logic [3:0]   key_addr = '0;
  logic [127:0] key_data = '0;
  logic         req_main = 1'b0;
  logic         req_aux = 1'b0;
  logic         mode = 1'b0;
  logic [127:0] data_in = '0;
  logic         ack = 1'b0;
  logic         busy [NI];
  logic         valid [NI];
  logic [127:0] dout [NI];

  exp_t exp_q [NI][$];
  logic vprev [NI];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    kuznechik_crypt #(.L_UNROLL(1 << g)) u_dut (
      .clk_i      (clk),
      .resetn_i   (rst_n),
      .key_we_i   (key_we),
      .key_addr_i (key_addr),
      .key_data_i (key_data),
      .request_i  ((g == 0) ? req_main : req_aux),
      .mode_i     (mode),
      .data_i     (data_in),
      .ack_i      (ack),
      .busy_o     (busy[g]),
      .valid_o    (valid[g]),
      .data_o     (dout[g])
    );
  end

  task automatic chk_d(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_n(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h01C3 << (i - 8));
    return p[7:0];
  endfunction

  // Reference for zero round keys: nine rounds of S then L.
  function automatic logic [127:0] ref_zero_key(input logic [127:0] x);
    logic [127:0] s;
    logic [7:0]   l;
    s = x;
    for (int r = 0; r < 9; r++) begin
      for (int j = 0; j < 16; j++) s[8*j +: 8] = PI_REF[s[8*j +: 8]];
      for (int t = 0; t < 16; t++) begin
        l = '0;
        for (int k = 0; k < 16; k++) l = l ^ gmul(COEF[k], s[127-8*k -: 8]);
        s = {l, s[127:8]};
      end
    end
    return s;
  endfunction

  // Monitor: each rising valid_o pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (valid[i] && !vprev[i]) begin
        if (exp_q[i].size() == 0) begin
          chk_n($sformatf("unexpected_result[%0d]", i), 1, 0);
        end else begin
          e = exp_q[i].pop_front();
          chk_d($sformatf("data_o[%0d]", i), dout[i], e.d);
          chk_n($sformatf("latency[%0d]", i), cyc - e.t0, e.lat);
        end
      end
      vprev[i] = valid[i];
    end
  end

  task automatic push(int i, logic [127:0] d);
    exp_t e;
    e.d = d;
    e.lat = 19 + 144 / (1 << i);
    e.t0 = cyc + 1;
    exp_q[i].push_back(e);
  endtask

  task automatic start(logic m, logic [127:0] d, logic aux);
    mode = m;
    data_in = d;
    req_main = 1'b1;
    req_aux = aux;
    @(negedge clk);
    req_main = 1'b0;
    req_aux = 1'b0;
  endtask

  task automatic write_key(int a, logic [127:0] k);
    key_we = 1'b1;
    key_addr = 4'(a);
    key_data = k;
    @(negedge clk);
    key_we = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_valid(string nm, int lim);
    int k;
    k = 0;
    while (!valid[0] && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk_n({nm, "_valid_seen"}, int'(valid[0]), 1);
  endtask

  task automatic wait_all(string nm, int lim);
    int k;
    int n;
    k = 0;
    n = 1;
    while (n != 0 && k < lim) begin
      @(negedge clk);
      k++;
      n = 0;
      for (int i = 0; i < NI; i++) n += exp_q[i].size();
    end
    chk_n({nm, "_pending"}, n, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] hold;
    int bad;
    for (int i = 0; i < NI; i++) vprev[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk_n($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
      chk_n($sformatf("rst_valid[%0d]", i), int'(valid[i]), 0);
      chk_d($sformatf("rst_data[%0d]", i), dout[i], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 10; a < 16; a++) write_key(a, '1);
    for (int a = 0; a < 10; a++) write_key(a, KA[a]);

    for (int i = 0; i < NI; i++) push(i, CT);
    start(1'b0, PT, 1'b1);
    wait_all("enc_all", 400);
    do_ack();
    for (int i = 0; i < NI; i++)
      chk_n($sformatf("ack_valid[%0d]", i), int'(valid[i]), 0);

    for (int i = 0; i < NI; i++) push(i, PT);
    start(1'b1, CT, 1'b1);
    wait_all("dec_all", 400);
    do_ack();

    push(0, CT);
    start(1'b0, PT, 1'b0);
    wait_valid("b2b_first", 300);
    push(0, PT);
    mode = 1'b1;
    data_in = CT;
    req_main = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    req_main = 1'b0;
    ack = 1'b0;
    chk_n("b2b_valid_low", int'(valid[0]), 0);
    chk_n("b2b_busy_high", int'(busy[0]), 1);
    wait_valid("b2b_second", 300);
    do_ack();

    push(0, PT);
    start(1'b1, CT, 1'b0);
    repeat (10) @(negedge clk);
    key_we = 1'b1;
    key_addr = 4'd0;
    key_data = '0;
    req_main = 1'b1;
    mode = 1'b0;
    data_in = PT;
    ack = 1'b1;
    @(negedge clk);
    key_we = 1'b0;
    req_main = 1'b0;
    ack = 1'b0;
    wait_valid("busy_wr", 300);
    do_ack();
    repeat (3) @(negedge clk);
    chk_n("no_queued_req_busy", int'(busy[0]), 0);

    push(0, CT);
    start(1'b0, PT, 1'b0);
    wait_valid("hold", 300);
    hold = dout[0];
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (dout[0] !== hold || valid[0] !== 1'b1) bad++;
    end
    chk_n("hold_unstable_cycles", bad, 0);
    do_ack();
    chk_n("idle_valid", int'(valid[0]), 0);
    chk_n("idle_busy", int'(busy[0]), 0);
    chk_d("idle_data_kept", dout[0], CT);

    start(1'b0, PT, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_n("async_rst_busy", int'(busy[0]), 0);
    chk_n("async_rst_valid", int'(valid[0]), 0);
    chk_d("async_rst_data", dout[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(0, ref_zero_key('0));
    start(1'b0, '0, 1'b0);
    wait_valid("zero_key", 300);
    do_ack();

    repeat (5) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk_n($sformatf("queue_left[%0d]", i), exp_q[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
